// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer: inserts a complement bit after STUFF_LEN identical bits.
// Optional stuff counter output when CAN_STUFF_STATS_EN is defined.
module can_bit_stuffer #(
  parameter int STUFF_LEN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_point,
  input  logic       stuff_en,
  input  logic       bit_in,
  output logic       bit_req,
  output logic       tx_out,
  output logic       stuff_bit
`ifdef CAN_STUFF_STATS_EN
  ,
  output logic [7:0] stuff_count
`endif
);

  // Handshake: sample_point is the slot strobe (valid); bit_req pulses for one
  // cycle after any slot that consumed bit_in (ready/accept). Stuff slots never accept.
  localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);

  logic       last_bit;
  logic [2:0] run_cnt;
  logic       stuff_pend;
  logic [2:0] run_next;

  // run_cnt == 0 marks the first bit of a stuffed region: always starts a new run.
  always_comb begin
    run_next = 3'd1;
    if (run_cnt != 3'd0 && bit_in == last_bit) begin
      run_next = run_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out     <= 1'b1;
      stuff_bit  <= 1'b0;
      bit_req    <= 1'b0;
      last_bit   <= 1'b1;
      run_cnt    <= 3'd0;
      stuff_pend <= 1'b0;
    end else if (sample_point) begin
      if (stuff_pend) begin
        tx_out     <= ~last_bit;
        stuff_bit  <= 1'b1;
        bit_req    <= 1'b0;
        last_bit   <= ~last_bit;
        run_cnt    <= 3'd1;
        stuff_pend <= 1'b0;
      end else if (stuff_en) begin
        tx_out     <= bit_in;
        stuff_bit  <= 1'b0;
        bit_req    <= 1'b1;
        last_bit   <= bit_in;
        run_cnt    <= run_next;
        stuff_pend <= (run_next == RUN_MAX);
      end else begin
        tx_out     <= bit_in;
        stuff_bit  <= 1'b0;
        bit_req    <= 1'b1;
        last_bit   <= bit_in;
        run_cnt    <= 3'd0;
      end
    end else begin
      bit_req <= 1'b0;
    end
  end

`ifdef CAN_STUFF_STATS_EN
  logic stuff_en_d;

  // A new frame (stuff_en rising) restarts the count; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stuff_en_d  <= 1'b0;
      stuff_count <= 8'd0;
    end else begin
      stuff_en_d <= stuff_en;
      if (stuff_en && !stuff_en_d) begin
        stuff_count <= 8'd0;
      end else if (sample_point && stuff_pend && stuff_count != 8'hFF) begin
        stuff_count <= stuff_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Self-checking bench for can_bit_stuffer: directed frames plus random frames
// checked against a frame-level stuffing model.
module tb_can_bit_stuffer;

  localparam int STUFF_LEN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_point = 1'b0;
  logic stuff_en = 1'b0;
  logic bit_in = 1'b0;
  logic bit_req;
  logic tx_out;
  logic stuff_bit;
`ifdef CAN_STUFF_STATS_EN
  logic [7:0] stuff_count;
`endif

  can_bit_stuffer #(.STUFF_LEN(STUFF_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_point (sample_point),
    .stuff_en     (stuff_en),
    .bit_in       (bit_in),
    .bit_req      (bit_req),
    .tx_out       (tx_out),
    .stuff_bit    (stuff_bit)
`ifdef CAN_STUFF_STATS_EN
    ,
    .stuff_count  (stuff_count)
`endif
  );

  always #5 clk = ~clk;

  // Slot entry: [3]=stuff_en to drive, [2]=bit_in to drive, [1]=expected tx_out, [0]=expected stuff_bit
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int gap_fixed = 0;
  logic last_tx = 1'b1;
  logic last_stf = 1'b0;
  logic prev_en = 1'b0;
  int cur_stuffs = 0;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
  endtask

`ifdef CAN_STUFF_STATS_EN
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask
`endif

  // Model: the stuffed stream of a frame is its bits with a complement appended
  // whenever the last STUFF_LEN transmitted bits (stuff bits included) are identical.
  task automatic add_frame(input logic [63:0] bits, input int n, input int npass);
    bit win[$];
    bit b;
    bit same;
    bit p;
    for (int i = 0; i < n; i++) begin
      b = bits[i];
      exp_q.push_back({1'b1, b, b, 1'b0});
      win.push_back(b);
      if (win.size() >= STUFF_LEN) begin
        same = 1'b1;
        for (int k = 1; k < STUFF_LEN; k++) begin
          if (win[win.size() - 1 - k] != b) same = 1'b0;
        end
        if (same) begin
          exp_q.push_back({(i == n - 1) ? 1'b0 : 1'b1, 1'($urandom), ~b, 1'b1});
          win.push_back(~b);
        end
      end
    end
    for (int j = 0; j < npass; j++) begin
      p = 1'($urandom);
      exp_q.push_back({1'b0, p, p, 1'b0});
    end
  endtask

  task automatic do_slot(input logic [3:0] s);
    int gap;
    @(negedge clk);
    sample_point = 1'b1;
    stuff_en = s[3];
    bit_in = s[2];
    @(posedge clk);
    #1;
    chk("tx_out", tx_out, s[1]);
    chk("stuff_bit", stuff_bit, s[0]);
    chk("bit_req", bit_req, ~s[0]);
    last_tx = s[1];
    last_stf = s[0];
`ifdef CAN_STUFF_STATS_EN
    if (s[3] && !prev_en) cur_stuffs = 0;
    if (s[0] && cur_stuffs < 255) cur_stuffs++;
    chk8("stuff_count", stuff_count, 8'(cur_stuffs));
`endif
    prev_en = s[3];
    gap = (gap_fixed >= 0) ? gap_fixed : $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sample_point = 1'b0;
      bit_in = 1'($urandom);
      @(posedge clk);
      #1;
      chk("tx_hold", tx_out, last_tx);
      chk("stuff_hold", stuff_bit, last_stf);
      chk("req_idle", bit_req, 1'b0);
    end
  endtask

  task automatic run_queue(input int limit);
    int n = 0;
    while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
      do_slot(exp_q.pop_front());
      n++;
    end
  endtask

  // Reset is asserted together with a sample_point so the override is exercised.
  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    sample_point = 1'b1;
    stuff_en = 1'b1;
    bit_in = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      chk("rst_tx", tx_out, 1'b1);
      chk("rst_stuff", stuff_bit, 1'b0);
      chk("rst_req", bit_req, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    sample_point = 1'b0;
    stuff_en = 1'b0;
    last_tx = 1'b1;
    last_stf = 1'b0;
    prev_en = 1'b0;
    cur_stuffs = 0;
  endtask

  initial begin
    logic [63:0] bits;
    logic cur;
    int n;

    apply_reset(2);

    // Held sample_point: basic stuff, long run of ones, stuff bit starting a run.
    gap_fixed = 0;
    add_frame(64'h20, 6, 2);
    run_queue(-1);
    add_frame(64'h3FF, 10, 2);
    run_queue(-1);
    add_frame(64'h1E0, 9, 2);
    run_queue(-1);
    // Region ends on the fifth identical bit: the stuff bit follows with stuff_en low.
    add_frame(64'h0, 5, 2);
    run_queue(-1);

    // Reset while a stuff bit is pending, then a fresh run of zeros.
    add_frame(64'h0, 5, 1);
    run_queue(5);
    exp_q.delete();
    apply_reset(1);
    add_frame(64'h20, 6, 2);
    run_queue(-1);

    // Sparse strobe: one slot every fourth cycle.
    gap_fixed = 3;
    add_frame(64'h3FF, 10, 2);
    add_frame(64'h1E0, 9, 2);
    run_queue(-1);

    // Random frames with biased runs and random strobe spacing.
    gap_fixed = -1;
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(8, 48);
      cur = 1'($urandom);
      bits = '0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) cur = ~cur;
        bits[i] = cur;
      end
      add_frame(bits, n, $urandom_range(1, 3));
      run_queue(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/can_bit_stuffer.md
CAN_BIT_STUFFER -- requirements
Module: can_bit_stuffer

Interface
REQ-001 SHALL: parameter STUFF_LEN, default 5, number of consecutive identical bits after which a stuff bit is inserted (legal 2..7).
REQ-002 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL: sample_point  input  1  bit-time strobe; one bit slot per cycle it is high (may be held high continuously).
REQ-005 SHALL: stuff_en  input  1  high while the frame's stuffed region (SOF through CRC sequence) is being sent.
REQ-006 SHALL: bit_in  input  1  next unstuffed bit from the frame transmitter.
REQ-007 SHALL: bit_req  output  1  one-cycle pulse: bit_in was consumed; upstream advances to its next bit.
REQ-008 SHALL: tx_out  output  1  stuffed serial bit to the bus driver (1 = recessive).
REQ-009 SHALL: stuff_bit  output  1  high for the bit slot in which tx_out carries an inserted stuff bit.

Function
REQ-010 SHALL: Internal state: last_bit (1 bit), run_cnt (3 bits, 0..STUFF_LEN), stuff_pend (1 bit).
REQ-011 SHALL: Cycles with sample_point low change no state; bit_req is 0.
REQ-012 SHALL: Latency: on a sample_point cycle, tx_out, stuff_bit and bit_req update at that clock edge (visible the following cycle); one register stage.
REQ-013 SHALL: STUFF slot (sample_point and stuff_pend): tx_out <= ~last_bit, stuff_bit <= 1, bit_req <= 0, last_bit <= ~last_bit, run_cnt <= 1, stuff_pend <= 0; bit_in ignored.
REQ-014 SHALL: DATA slot with stuff_en (sample_point, !stuff_pend, stuff_en): tx_out <= bit_in, stuff_bit <= 0, bit_req <= 1; run_cnt <= (bit_in == last_bit) ? run_cnt+1 : 1; last_bit <= bit_in.
REQ-015 SHALL: stuff_pend <= 1 when the DATA-slot update makes run_cnt equal STUFF_LEN; run_cnt never exceeds STUFF_LEN.
REQ-016 SHALL: First DATA slot after stuff_en rises (run_cnt == 0) loads run_cnt <= 1 regardless of last_bit.
REQ-017 SHALL: PASS slot (sample_point, !stuff_pend, !stuff_en): tx_out <= bit_in, bit_req <= 1, stuff_bit <= 0, run_cnt <= 0.
REQ-018 SHALL: A stuff bit pending when stuff_en falls is still emitted in the next slot (stuff after final CRC bit), then PASS behaviour resumes.
REQ-019 SHALL: stuff_bit and bit_req are never high together; bit_req is low in exactly one slot per stuff bit inserted.
REQ-020 SHALL: Between sample points tx_out holds its last value.

Reset
REQ-021 SHALL: While rst is high at a clock edge: tx_out <= 1, stuff_bit <= 0, bit_req <= 0, last_bit <= 1, run_cnt <= 0, stuff_pend <= 0.
REQ-022 SHALL: rst overrides sample_point in the same cycle; a reset mid-frame drops any pending stuff bit and the run count.
REQ-023 SHALL: First sample_point after rst deasserts is treated as a fresh slot per REQ-014..REQ-017.

Configuration
REQ-024 SHALL: Macro CAN_STUFF_STATS_EN, when defined, adds output stuff_count (8 bits): increments on every STUFF slot, saturates at 255, clears on rst and on each rising edge of stuff_en.
REQ-025 SHALL: Without CAN_STUFF_STATS_EN the stuff_count port and its logic are absent; all other behaviour identical.

Verification
REQ-026 SHALL: stuff_en=1, sample_point held 1, bit_in = 0,0,0,0,0,1 -> tx_out = 0,0,0,0,0,1(stuff),1; bit_req low only in the 6th slot; stuff_bit high only there.
REQ-027 SHALL: stuff_en=1, bit_in = 1 x10 -> tx_out = 11111 0 11111 0; second stuff counts toward next run (run_cnt=1 after stuff); stuff_count=2 with macro.
REQ-028 SHALL: Stuff bit then 4 bits equal to it, e.g. bit_in 0,0,0,0,0 then 1,1,1,1 -> tx_out 00000 1 1111 0 (stuff bit starts the new run).
REQ-029 SHALL: stuff_en falls on the same slot the 5th identical bit 0 is sent -> next slot still outputs stuff 1 with bit_req=0; following slot passes bit_in unchanged.
REQ-030 SHALL: rst asserted for one cycle while stuff_pend=1 -> next cycle tx_out=1, stuff_bit=0, bit_req=0; subsequent 5 zeros produce a stuff bit only after the 5th new zero.
REQ-031 SHALL: sample_point pulsed every 4th cycle -> outputs change only on edges after pulses; tx_out stable in between; bit_req single-cycle.
